// File: rtl/vector_stream_controller.sv
// ============================================================================
// Module   : vector_stream_controller
// Brief    : Parses an opcode/length stream and writes vector data to memory.
//            Optional macro: VSC_ADDR_RANGE_CHECK_EN (reject oversized totals).
// Revision : 1.0
// ============================================================================
`default_nettype none

module vector_stream_controller #(
  parameter int ELEMENT_WIDTH = 3,
  parameter int ADDR_WIDTH    = 17,
  parameter int NUM_VECTORS   = 2,
  localparam int EW = ELEMENT_WIDTH * 8,
  localparam int VS = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [EW-1:0]             in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mem_ready,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [EW-1:0]             mem_wdata,
  output logic [VS-1:0]             vec_sel,
  output logic [NUM_VECTORS*EW-1:0] lengths,
  output logic [2:0]                state,
  output logic                      done,
  output logic                      error
);

  localparam int TW = EW + VS;
  localparam logic [7:0] C_OP_NOP   = 8'h00;
  localparam logic [7:0] C_OP_START = 8'h01;
  localparam logic [7:0] C_OP_CLEAR = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_METADATA = 3'd1,
    S_VECTORS  = 3'd2,
    S_DONE     = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  state_t                  r_state;
  logic [VS-1:0]           r_meta_cnt;
  logic [TW-1:0]           r_cnt;
  logic [TW-1:0]           r_total;
  logic [NUM_VECTORS*EW-1:0] r_lengths;
  logic                    r_done;
  logic                    r_error;

  logic                    w_hs;
  logic                    w_meta_last;
  logic [TW-1:0]           w_total;
  logic [TW-1:0]           w_cnt_next;
  logic [TW-1:0]           w_acc;
  logic                    w_found;
  logic [VS-1:0]           w_vec_sel;
  logic                    w_range_err;

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_IDLE, S_METADATA, S_ERROR: in_ready = 1'b1;
      S_VECTORS:                   in_ready = mem_ready;
      default:                     in_ready = 1'b0;
    endcase
  end

  assign w_hs        = in_valid && in_ready;
  assign w_meta_last = (r_meta_cnt == VS'(NUM_VECTORS - 1));
  assign w_cnt_next  = r_cnt + TW'(1);

  // The final length arrives on in_data, so the total includes it directly.
  always_comb begin
    w_total = TW'(in_data);
    for (int k = 0; k < NUM_VECTORS - 1; k++) begin
      w_total = w_total + TW'(r_lengths[k*EW +: EW]);
    end
  end

  always_comb begin
    w_acc     = '0;
    w_found   = 1'b0;
    w_vec_sel = '0;
    for (int k = 0; k < NUM_VECTORS; k++) begin
      w_acc = w_acc + TW'(r_lengths[k*EW +: EW]);
      if (!w_found && (r_cnt < w_acc)) begin
        w_vec_sel = VS'(k);
        w_found   = 1'b1;
      end
    end
    if (r_state != S_VECTORS) begin
      w_vec_sel = '0;
    end
  end

`ifdef VSC_ADDR_RANGE_CHECK_EN
  generate
    if (ADDR_WIDTH >= TW) begin : g_range_never
      assign w_range_err = 1'b0;
    end else begin : g_range_cmp
      assign w_range_err = (w_total > (TW'(1) << ADDR_WIDTH));
    end
  endgenerate
`else
  assign w_range_err = 1'b0;
`endif

  generate
    if (ADDR_WIDTH <= TW) begin : g_addr_slice
      assign mem_addr = r_cnt[ADDR_WIDTH-1:0];
    end else begin : g_addr_ext
      assign mem_addr = {{(ADDR_WIDTH-TW){1'b0}}, r_cnt};
    end
  endgenerate

  assign mem_we    = (r_state == S_VECTORS) && in_valid && mem_ready;
  assign mem_wdata = in_data;
  assign vec_sel   = w_vec_sel;
  assign lengths   = r_lengths;
  assign state     = r_state;
  assign done      = r_done;
  assign error     = r_error;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_meta_cnt <= '0;
      r_cnt      <= '0;
      r_total    <= '0;
      r_lengths  <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            if (in_data[7:0] == C_OP_START) begin
              r_state    <= S_METADATA;
              r_meta_cnt <= '0;
            end else if (in_data[7:0] != C_OP_NOP) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
        S_METADATA: begin
          if (w_hs) begin
            r_lengths[r_meta_cnt*EW +: EW] <= in_data;
            if (w_meta_last) begin
              r_total    <= w_total;
              r_meta_cnt <= '0;
              if (w_total == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else if (w_range_err) begin
                r_state <= S_ERROR;
                r_error <= 1'b1;
              end else begin
                r_state <= S_VECTORS;
                r_cnt   <= '0;
              end
            end else begin
              r_meta_cnt <= r_meta_cnt + 1'b1;
            end
          end
        end
        S_VECTORS: begin
          if (w_hs) begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == r_total) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        S_ERROR: begin
          if (w_hs && (in_data[7:0] == C_OP_CLEAR)) begin
            r_state <= S_IDLE;
            r_error <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_stream_controller.sv
// ============================================================================
// Module   : tb_vector_stream_controller
// Brief    : Directed bench with a write scoreboard for vector_stream_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vector_stream_controller;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_ready;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [0:0]  vec_sel;
  logic [47:0] lengths;
  logic [2:0]  state;
  logic        done;
  logic        error;

  vector_stream_controller #(
    .ELEMENT_WIDTH(3),
    .ADDR_WIDTH   (AW),
    .NUM_VECTORS  (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_ready(mem_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .vec_sel  (vec_sel),
    .lengths  (lengths),
    .state    (state),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    int            sel;
  } wr_t;

  wr_t exp_q[$];
  int  sel_log[$];
  int  addr_log[$];
  int  n_total  = 0;
  int  n_pass   = 0;
  int  n_done   = 0;
  int  n_writes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a transfer of lengths l0,l1 produces writes i = 0..l0+l1-1 at
  // address i mod 2**AW, data base+i, vector 0 for the first l0 elements.
  task automatic expect_transfer(input int l0, input int l1, input logic [23:0] base);
    for (int i = 0; i < l0 + l1; i++) begin
      wr_t w;
      w.addr = AW'(i % (1 << AW));
      w.data = base + 24'(i);
      w.sel  = (i < l0) ? 0 : 1;
      exp_q.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (done) n_done++;
    if (mem_we) begin
      n_writes++;
      sel_log.push_back(int'(vec_sel));
      addr_log.push_back(int'(mem_addr));
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(w.addr));
        chk("wr_data", 64'(mem_wdata), 64'(w.data));
        chk("wr_sel", 64'(vec_sel), 64'(w.sel));
        chk("wr_handshake", {62'd0, in_valid, mem_ready}, 64'd3);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d);
    int   t  = 0;
    logic hs = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    while (!hs && t < 100) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!hs) chk("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int v;
    int d0;
    int w0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_lengths", 64'(lengths), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    tick();

    // Basic transfer: lengths 3,2, data A..E
    expect_transfer(3, 2, 24'h00000A);
    send(24'h000001);
    chk("t1_meta_state", 64'(state), 64'd1);
    send(24'd3);
    send(24'd2);
    chk("t1_lengths", 64'(lengths), {16'd0, 24'd2, 24'd3});
    chk("t1_vec_state", 64'(state), 64'd2);
    sel_log.delete();
    for (int i = 0; i < 5; i++) send(24'h00000A + 24'(i));
    chk("t1_done_state", 64'(state), 64'd3);
    chk("t1_done_flag", 64'(done), 64'd1);
    tick();
    chk("t1_idle_state", 64'(state), 64'd0);
    chk("t1_done_clear", 64'(done), 64'd0);
    v = 0;
    foreach (sel_log[i]) v += sel_log[i] << i;
    chk("t1_vecsel_seq", 64'(v), 64'd24);
    chk("t1_vecsel_cnt", 64'(sel_log.size()), 64'd5);
    chk("t1_all_written", 64'(exp_q.size()), 64'd0);
    chk("t1_done_pulses", 64'(n_done), 64'd1);

    // Back-pressure from memory after the second data element
    d0 = n_done;
    expect_transfer(3, 2, 24'h000100);
    send(24'h000001);
    send(24'd3);
    send(24'd2);
    send(24'h000100);
    send(24'h000101);
    mem_ready = 1'b0;
    in_data   = 24'h000102;
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_ready", 64'(in_ready), 64'd0);
      chk("t2_stall_we", 64'(mem_we), 64'd0);
      chk("t2_stall_addr", 64'(mem_addr), 64'd2);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    send(24'h000102);
    send(24'h000103);
    send(24'h000104);
    chk("t2_done_state", 64'(state), 64'd3);
    tick();
    chk("t2_all_written", 64'(exp_q.size()), 64'd0);
    chk("t2_done_pulses", 64'(n_done - d0), 64'd1);

    // Zero-length transfer
    w0 = n_writes;
    d0 = n_done;
    send(24'h000001);
    send(24'd0);
    send(24'd0);
    chk("t3_done_state", 64'(state), 64'd3);
    chk("t3_done_flag", 64'(done), 64'd1);
    tick();
    chk("t3_idle_state", 64'(state), 64'd0);
    chk("t3_no_writes", 64'(n_writes - w0), 64'd0);
    chk("t3_done_pulses", 64'(n_done - d0), 64'd1);

    // Bad opcode, discarded elements, then clear
    send(24'h000007);
    chk("t4_err_state", 64'(state), 64'd4);
    chk("t4_err_flag", 64'(error), 64'd1);
    send(24'h000005);
    send(24'h000001);
    chk("t4_err_held", 64'(error), 64'd1);
    chk("t4_err_state_held", 64'(state), 64'd4);
    send(24'h000002);
    chk("t4_clear_state", 64'(state), 64'd0);
    chk("t4_clear_flag", 64'(error), 64'd0);
    chk("t4_no_writes", 64'(n_writes - w0), 64'd0);

    // Reset mid-transfer, then a fresh 1+1 transfer
    expect_transfer(3, 2, 24'h000200);
    send(24'h000001);
    send(24'd3);
    send(24'd2);
    send(24'h000200);
    send(24'h000201);
    in_data  = 24'h000202;
    in_valid = 1'b1;
    reset_n  = 1'b0;
    #1;
    chk("t5_rst_state", 64'(state), 64'd0);
    chk("t5_rst_we", 64'(mem_we), 64'd0);
    chk("t5_rst_addr", 64'(mem_addr), 64'd0);
    chk("t5_rst_sel", 64'(vec_sel), 64'd0);
    chk("t5_rst_lengths", 64'(lengths), 64'd0);
    exp_q.delete();
    w0 = n_writes;
    tick();
    tick();
    in_valid = 1'b0;
    reset_n  = 1'b1;
    tick();
    chk("t5_release_state", 64'(state), 64'd0);
    chk("t5_no_writes_in_reset", 64'(n_writes - w0), 64'd0);
    expect_transfer(1, 1, 24'h000300);
    addr_log.delete();
    send(24'h000001);
    send(24'd1);
    send(24'd1);
    send(24'h000300);
    send(24'h000301);
    chk("t5_done_state", 64'(state), 64'd3);
    tick();
    chk("t5_all_written", 64'(exp_q.size()), 64'd0);
    chk("t5_addr_pair", 64'((addr_log.size() == 2) ? addr_log[1] * 16 + addr_log[0] : -1), 64'd16);

    // Total larger than the address space (2**4)
    w0 = n_writes;
    d0 = n_done;
`ifdef VSC_ADDR_RANGE_CHECK_EN
    send(24'h000001);
    send(24'd10);
    send(24'd10);
    chk("t6_range_state", 64'(state), 64'd4);
    chk("t6_range_error", 64'(error), 64'd1);
    send(24'h000002);
    chk("t6_clear_state", 64'(state), 64'd0);
    chk("t6_no_writes", 64'(n_writes - w0), 64'd0);
`else
    expect_transfer(10, 10, 24'h000400);
    addr_log.delete();
    send(24'h000001);
    send(24'd10);
    send(24'd10);
    for (int i = 0; i < 20; i++) begin
      if (i == 19) chk("t6_not_done_early", 64'(state), 64'd2);
      send(24'h000400 + 24'(i));
    end
    chk("t6_done_state", 64'(state), 64'd3);
    tick();
    chk("t6_all_written", 64'(exp_q.size()), 64'd0);
    chk("t6_write_count", 64'(n_writes - w0), 64'd20);
    chk("t6_done_pulses", 64'(n_done - d0), 64'd1);
    chk("t6_wrap_hi", 64'((addr_log.size() == 20) ? addr_log[15] : -1), 64'd15);
    chk("t6_wrap_lo", 64'((addr_log.size() == 20) ? addr_log[16] : -1), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vector_stream_controller.md
VECTOR_STREAM_CONTROLLER -- requirements
Module: vector_stream_controller

Interface
REQ-001 SHALL have parameter ELEMENT_WIDTH, default 3: element width in bytes (EW = ELEMENT_WIDTH*8 bits).
REQ-002 SHALL have parameter ADDR_WIDTH, default 17: memory address width.
REQ-003 SHALL have parameter NUM_VECTORS, default 2, legal range 1..8: vectors per transfer (VS = max(1,$clog2(NUM_VECTORS))).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  EW  stream element (opcode, length or vector data).
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  element accepted when in_valid && in_ready (handshake).
REQ-009 SHALL have port mem_ready  input  1  memory can take a write this cycle.
REQ-010 SHALL have port mem_we  output  1  write strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_WIDTH  write address.
REQ-012 SHALL have port mem_wdata  output  EW  write data.
REQ-013 SHALL have port vec_sel  output  VS  index of vector currently being written.
REQ-014 SHALL have port lengths  output  NUM_VECTORS*EW  captured lengths; vector k at bits [k*EW +: EW].
REQ-015 SHALL have ports state (output, 3: current state), done (output, 1: completion pulse), error (output, 1: sticky error flag).

Function
REQ-016 SHALL implement states IDLE=0, METADATA=1, VECTORS=2, DONE=3, ERROR=4; state output SHALL equal the current state.
REQ-017 in_ready SHALL be 1 in IDLE, METADATA and ERROR; mem_ready in VECTORS; 0 in DONE.
REQ-018 IDLE, on handshake: in_data[7:0]=8'h01 -> METADATA, metadata counter cleared; 8'h00 -> stay IDLE (nop); any other -> ERROR.
REQ-019 METADATA: k-th handshaken element (k=0..NUM_VECTORS-1) SHALL be stored as length k; after element NUM_VECTORS-1, total = sum of lengths computed at EW+VS bits without truncation.
REQ-020 On completing METADATA: total==0 -> DONE; else -> VECTORS with element counter cnt (EW+VS bits) cleared.
REQ-021 VECTORS: mem_we = in_valid && mem_ready (combinational); mem_wdata = in_data; mem_addr = cnt[ADDR_WIDTH-1:0]; cnt increments per handshake.
REQ-022 VECTORS: handshake with cnt+1==total -> DONE next cycle.
REQ-023 vec_sel SHALL equal the smallest k with cnt < len0+...+lenk; zero-length vectors therefore never selected; vec_sel=0 outside VECTORS.
REQ-024 DONE SHALL last exactly one cycle, done=1 for that cycle only, cnt cleared, then IDLE; lengths retained until next METADATA.
REQ-025 ERROR: error=1; elements consumed and discarded; in_data[7:0]=8'h02 -> IDLE with error cleared next cycle.
REQ-026 in_valid without handshake SHALL change nothing; mem_we SHALL be 0 outside VECTORS.

Reset
REQ-027 reset_n low SHALL immediately force state=IDLE, cnt=0, metadata counter=0, lengths=0, done=0, error=0, vec_sel=0, mem_we=0, mem_addr=0.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer with no further mem_we; first cycle after release SHALL be IDLE.

Configuration
REQ-029 Macro VSC_ADDR_RANGE_CHECK_EN defined: on completing METADATA, total > 2**ADDR_WIDTH -> ERROR instead of VECTORS, no writes.
REQ-030 Macro VSC_ADDR_RANGE_CHECK_EN undefined: no check; mem_addr wraps modulo 2**ADDR_WIDTH; termination still at cnt+1==total.

Verification
REQ-031 Stream 01,3,2,A,B,C,D,E with mem_ready=1 -> writes A..E at addr 0..4, vec_sel 0,0,0,1,1, single done pulse, then IDLE.
REQ-032 Same stream, mem_ready low 3 cycles after 2nd data -> in_ready low, no mem_we, cnt held; completes with identical addr/data.
REQ-033 Stream 01,0,0 -> DONE immediately after metadata, no mem_we, done pulse.
REQ-034 Opcode 8'h07 in IDLE -> ERROR, error=1 held through data elements; 8'h02 -> IDLE, error=0.
REQ-035 reset_n low after 2 of 5 data writes -> immediate IDLE, outputs at reset values; new 01,1,1,X,Y transfer writes addr 0,1.
REQ-036 ADDR_WIDTH=4, stream 01,10,10 -> with VSC_ADDR_RANGE_CHECK_EN: ERROR; without: 20 writes, addr wraps 15->0, done after 20th.
